fetch_queue: RTL and testbench

Parametrised fetch stage with a prefetch instruction queue. It drives a single-outstanding read port on instruction memory (cache/mem_system style Done/Stall handshake) and buffers returned instructions with their PCs in a DEPTH-entry FIFO. It presents them to decode under a valid/stall handshake and supports flush-with-redirect and sticky memory-error halt. It sits between the PC/branch-resolution logic and the IF/ID pipeline register.

---
 rtl/fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fetch_queue                                                            |
// | Fetch stage: single-outstanding imem reader feeding a prefetch FIFO.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fetch_queue #(
  parameter int                 DEPTH     = 4,
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h0800)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               mem_done,
  input  logic               mem_stall,
  input  logic               mem_err,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic [PC_W-1:0]    instr_pc2,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [PC_W-1:0]  PC_STEP = PC_W'(2);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic               mem_rd_q, mem_rd_d;
  logic               err_q, err_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_d [DEPTH];
  logic [PC_W-1:0]    fifo_pc_q [DEPTH];
  logic [PC_W-1:0]    fifo_pc_d [DEPTH];

  logic push, pop, issue;
  logic unused_stall;

  // Requests are held until mem_done no matter what, so mem_stall needs no handling.
  assign unused_stall = mem_stall;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_addr_d   = req_addr_q;
    err_d        = err_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    push         = 1'b0;
    issue        = 1'b0;
    pop          = (count_q != '0) && !id_stall && !flush;

    case (state_q)
      S_IDLE: begin
        if (!flush && (count_q < FULL) && !err_q) begin
          state_d = S_REQ;
          issue   = 1'b1;
        end
      end
      S_REQ: begin
        if (mem_done) begin
          if (flush) begin
            state_d = S_IDLE;
          end else if (mem_err) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_done) state_d = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (issue) req_addr_d = fetch_pc_q;

    if (flush)     fetch_pc_d = redirect_pc;
    else if (push) fetch_pc_d = fetch_pc_q + PC_STEP;

    if (push) begin
      fifo_instr_d[wr_ptr_q] = mem_data;
      fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
      wr_ptr_d               = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    mem_rd_d = (state_d == S_REQ) || (state_d == S_DISCARD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      mem_rd_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= NOP_INSTR;
        fifo_pc_q[i]    <= RESET_PC;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_addr_q   <= req_addr_d;
      mem_rd_q     <= mem_rd_d;
      err_q        <= err_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  // While a read is outstanding the address comes from the issue latch, not fetch_pc.
  assign mem_addr    = mem_rd_q ? req_addr_q : fetch_pc_q;
  assign mem_rd      = mem_rd_q;
  assign err         = err_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign instr_pc    = fifo_pc_q[rd_ptr_q];
  assign instr_pc2   = instr_pc + PC_STEP;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fetch_queue                                                         |
// | Directed scoreboard bench for fetch_queue with a latency-driven imem.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_stall = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_done = 1'b0;
  logic        mem_err = 1'b0;
  logic        mem_stall = 1'b0;
  logic [15:0] mem_addr, instr, instr_pc, instr_pc2;
  logic        mem_rd, instr_valid, err;

  logic [15:0] mem_data_b = 16'h0000;
  logic        mem_done_b = 1'b0;
  logic [15:0] mem_addr_b, instr_b, instr_pc_b, instr_pc2_b;
  logic        mem_rd_b, instr_valid_b, err_b;
  logic        zero_b;
  logic [15:0] zero16_b;
  assign zero_b   = 1'b0;
  assign zero16_b = 16'h0000;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic        err_en = 1'b0;
  logic [15:0] err_addr = 16'h0000;
  logic [15:0] sb [$];
  logic        cad_en = 1'b0;
  logic        have_last = 1'b0;
  int          last_pop = 0;
  logic        err_seen = 1'b0;
  int          n2 = 0;
  logic [15:0] cap_pc [4];
  logic [15:0] cap_in [4];
  logic [15:0] cap_p2 [4];

  fetch_queue dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_err(mem_err), .flush(flush), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pc2(instr_pc2), .err(err)
  );

  fetch_queue #(.RESET_PC(16'hFFFC)) dut_b (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_data(mem_data_b), .mem_done(mem_done_b), .mem_stall(zero_b),
    .mem_err(zero_b), .flush(zero_b), .redirect_pc(zero16_b),
    .id_stall(zero_b), .instr_valid(instr_valid_b), .instr(instr_b),
    .instr_pc(instr_pc_b), .instr_pc2(instr_pc2_b), .err(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: mem[a] = a, mem_done after lat extra cycles of mem_rd.
  always @(negedge clk) begin
    if (!rst || mem_done) begin
      mem_done = 1'b0;
      mem_err  = 1'b0;
      wcnt     = 0;
    end else if (mem_rd) begin
      if (wcnt >= lat) begin
        mem_done = 1'b1;
        mem_data = mem_addr;
        mem_err  = err_en && (mem_addr == err_addr);
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst || mem_done_b) mem_done_b = 1'b0;
    else if (mem_rd_b) begin
      mem_done_b = 1'b1;
      mem_data_b = mem_addr_b;
    end
  end

  // Scoreboard monitor: every accepted head is compared with the next expected PC.
  always @(negedge clk) begin
    if (rst) begin
      if (!instr_valid) chk("nop_when_invalid", instr, NOP);
      if (instr_valid && !id_stall && !flush) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_pop: observed pc=%h expected no entry", instr_pc);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          chk("pop_pc", instr_pc, e);
          chk("pop_instr", instr, e);
          chk("pop_pc2", instr_pc2, e + 16'd2);
          if (cad_en && have_last) chk("cadence", cyc - last_pop, 2);
          last_pop  = cyc;
          have_last = 1'b1;
        end
      end
      if (err_seen) begin
        chk("err_rise", err, 1'b1);
        err_seen = 1'b0;
      end
      if (mem_done && mem_err) begin
        chk("err_before", err, 1'b0);
        err_seen = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) n2 = 0;
    else if (instr_valid_b && n2 < 4) begin
      cap_pc[n2] = instr_pc_b;
      cap_in[n2] = instr_b;
      cap_p2[n2] = instr_pc2_b;
      n2++;
    end
  end

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [15:0] wrap_exp [4];
    int n;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 16'h0000);
    chk("rst_pc2", instr_pc2, 16'h0002);
    chk("rst_err", err, 1'b0);
    chk("rst_b_addr", mem_addr_b, 16'hFFFC);
    chk("rst_b_pc", instr_pc_b, 16'hFFFC);
    chk("rst_b_pc2", instr_pc2_b, 16'hFFFE);

    // Zero-wait streaming with 2-cycle cadence
    for (int i = 0; i < 4; i++) sb.push_back(16'(2 * i));
    id_stall = 1'b0;
    cad_en   = 1'b1;
    rst      = 1'b1;
    wait_drain(60);
    id_stall = 1'b1;
    cad_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("b_count", n2, 4);
    wrap_exp[0] = 16'hFFFC; wrap_exp[1] = 16'hFFFE;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      chk("b_wrap_pc", cap_pc[i], wrap_exp[i]);
      chk("b_wrap_instr", cap_in[i], wrap_exp[i]);
    end
    chk("b_pc2_of_fffe", cap_p2[1], 16'h0000);

    // Fill while decode stalls
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i >= 9) chk("full_no_rd", mem_rd, 1'b0);
    end
    chk("full_valid", instr_valid, 1'b1);
    chk("full_head_pc", instr_pc, 16'h0000);
    for (int i = 0; i < 5; i++) sb.push_back(16'(2 * i));
    id_stall = 1'b0;
    wait_drain(60);
    id_stall = 1'b1;

    // Flush while a slow read to 0x0010 is pending
    do_reset();
    lat = 3;
    for (int i = 0; i < 8; i++) sb.push_back(16'(2 * i));
    id_stall = 1'b0;
    n = 0;
    while (!(mem_rd && mem_addr == 16'h0010) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_req_0010", {mem_rd, mem_addr}, {1'b1, 16'h0010});
    chk("sb_empty_before_flush", sb.size(), 0);
    flush = 1'b1;
    redirect_pc = 16'h0040;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_invalid", instr_valid, 1'b0);
    chk("discard_rd_held", mem_rd, 1'b1);
    chk("discard_addr_held", mem_addr, 16'h0010);
    sb.push_back(16'h0040);
    sb.push_back(16'h0042);
    wait_drain(100);
    id_stall = 1'b1;
    chk("no_err_discard", err, 1'b0);

    // Flush coincident with mem_done and a pop
    do_reset();
    lat = 0;
    n = 0;
    while (!(mem_rd && instr_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_rd_and_valid", {mem_rd, instr_valid}, 2'b11);
    flush = 1'b1;
    redirect_pc = 16'h0080;
    id_stall = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_empty", instr_valid, 1'b0);
    chk("flush_done_idle", mem_rd, 1'b0);
    chk("flush_done_addr", mem_addr, 16'h0080);
    sb.push_back(16'h0080);
    sb.push_back(16'h0082);
    wait_drain(50);
    id_stall = 1'b1;

    // Memory error halts fetching
    do_reset();
    err_en   = 1'b1;
    err_addr = 16'h0006;
    for (int i = 0; i < 3; i++) sb.push_back(16'(2 * i));
    id_stall = 1'b0;
    wait_drain(50);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("halt_no_rd", mem_rd, 1'b0);
      chk("halt_err", err, 1'b1);
    end
    flush = 1'b1;
    redirect_pc = 16'h0100;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("halt_flush_no_rd", mem_rd, 1'b0);
    chk("halt_flush_err", err, 1'b1);
    chk("halt_flush_valid", instr_valid, 1'b0);
    err_en = 1'b0;

    // Asynchronous reset during an outstanding request
    do_reset();
    #1 chk("err_cleared", err, 1'b0);
    lat = 3;
    n = 0;
    while (!mem_rd && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_req", mem_rd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_rd", mem_rd, 1'b0);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_instr", instr, NOP);
    chk("arst_pc", instr_pc, 16'h0000);
    chk("arst_pc2", instr_pc2, 16'h0002);
    chk("arst_err", err, 1'b0);
    chk("arst_b_rd", mem_rd_b, 1'b0);
    chk("arst_b_addr", mem_addr_b, 16'hFFFC);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.push_back(16'h0000);
    wait_drain(50);
    id_stall = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
